sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO for BUS_WIDTH-bit words, in the memory library.
- Buffers words between a producer and a `register` stage. It sits upstream of that stage and drives its store strobe and data bus from the FIFO head.
- Decouples producer bursts from consumer store cadence; reports overflow and underflow.

Parameters:
- BUS_WIDTH, 8, data word width in bits (≥1).
- DEPTH, 8, number of entries. Must be a power of two and ≥2; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  push request.
- wr_data  input  BUS_WIDTH  word to push.
- full  output  1  high when count == DEPTH.
- rd_en  input  1  pop request; acknowledges the current rd_data.
- rd_data  output  BUS_WIDTH  head word; valid whenever empty is low.
- empty  output  1  high when count == 0.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge of clk. Polarity and synchronicity are fixed.
- Reset (rst high at an edge) sets:
  - write and read pointers = 0, count = 0;
  - empty = 1, full = 0, overflow = 0, underflow = 0;
  - rd_data = 0.
  Storage contents are not cleared.
- rst has priority over every other input. Reset asserted mid-burst discards all contents in that cycle. wr_en and rd_en in a reset cycle are ignored and set no flags.
- Pointers: ADDR_W = $clog2(DEPTH); pointers are ADDR_W+1 bits wide.
  - Index = low ADDR_W bits; wrap-around is natural modulo 2^(ADDR_W+1).
  - empty when the pointers are equal.
  - full when the index bits are equal and the MSBs differ.
- Push accepted = wr_en & ~full.
  - mem[wptr] <= wr_data; wptr increments.
  - A push while full is dropped, leaves state unchanged and sets overflow.
- Pop accepted = rd_en & ~empty.
  - rptr increments.
  - A pop while empty sets underflow; state unchanged.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, count unchanged.
  - Full: the pop is accepted and the push is rejected (full is evaluated pre-edge), so overflow is set.
  - Empty: the push is accepted and the pop is rejected, so underflow is set. No bypass: a word written into an empty FIFO is not poppable in the same cycle.
- FWFT latency:
  - rd_data = mem[rptr index] (combinational from storage), so it is visible from the edge after the push.
  - Empty-to-nonempty latency: 1 cycle.
  - When empty, rd_data = 0 (masked).
- full and empty derive combinationally from registered pointers; no glitch-sensitive paths.
- Sticky flags clear only on rst.
- Downstream use: `register` st = ~empty, d = rd_data, and rd_en is driven by the consumer once the store is taken.

Optional Feature:
- Macro: SYNC_FIFO_COUNT_EN.
- When defined:
  - Extra output port count, ADDR_W+1 bits wide, equal to wptr − rptr (range 0..DEPTH), registered alongside the pointers. Reset value 0.
  - Extra output almost_full = (count ≥ DEPTH−1).
- When undefined: neither port exists; the remaining behaviour is identical.

Decomposition:
- Shared package memory_pkg:
  - function clog2-safe ADDR_W helper;
  - default constants MEM_BUS_WIDTH = 8 and MEM_FIFO_DEPTH = 8;
  - typedef of the pointer width is derived locally (parameter-dependent).
- One natural sub-module: fifo_ptr_ctl.
  - Holds the two pointers, the full/empty comparison and the sticky flags.
  - The top holds the storage array and the read mux.

Test Plan:
- Reset then idle → empty=1, full=0, rd_data=0, overflow=0, underflow=0 for 5 cycles.
- Push 1,30,31 on consecutive cycles; then pop 3 times → rd_data shows 1 one cycle after the first push, then 30 and 31 in order; empty=1 after the 3rd pop.
- Push 9 words into DEPTH=8 → full=1 after the 8th push; the 9th is dropped and overflow=1. Draining then yields words 1..8 only.
- At full, assert wr_en=rd_en with wr_data=33 → head popped, 33 not stored, overflow=1. At half-full (4 entries), simultaneous push/pop → count stays 4 and FIFO order is preserved across pointer wrap (run 20 cycles).
- Pop while empty → underflow=1, rd_data=0, pointers unchanged. Assert rst mid-burst with 5 entries → next cycle empty=1, flags=0, and a subsequent push of 32 reads back 32.
- With SYNC_FIFO_COUNT_EN: count tracks 0→7 across pushes and almost_full rises exactly at count=7. Without the macro, compile with the count port absent.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared definitions for the memory library.
//   addr_w()        index width for a given entry count, never below 1
//   MEM_BUS_WIDTH   default data word width
//   MEM_FIFO_DEPTH  default FIFO entry count
package memory_pkg;

    localparam int unsigned MEM_BUS_WIDTH  = 8;
    localparam int unsigned MEM_FIFO_DEPTH = 8;

    // $clog2(1) is 0, which would leave a zero-width index slice.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
//   master: drives wr_en, wr_data, rd_en; observes the FIFO status and head word
//   slave : the FIFO side
//   Optional: count and almost_full exist only when SYNC_FIFO_COUNT_EN is defined.
interface sync_fifo_if
    import memory_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = MEM_BUS_WIDTH,
    parameter int unsigned DEPTH     = MEM_FIFO_DEPTH
);
    localparam int unsigned ADDR_W = addr_w(DEPTH);

    logic                 wr_en;
    logic [BUS_WIDTH-1:0] wr_data;
    logic                 full;
    logic                 rd_en;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 empty;
    logic                 overflow;
    logic                 underflow;
`ifdef SYNC_FIFO_COUNT_EN
    logic [ADDR_W:0]      count;
    logic                 almost_full;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, overflow, underflow, count, almost_full
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, overflow, underflow, count, almost_full
    );
`else
    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, overflow, underflow
    );
`endif
endinterface

// File: rtl/fifo_ptr_ctl.sv
// Pointer and status control for sync_fifo.
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i/rd_en_i push/pop requests
//   push_o          accepted push (storage write strobe), widx_o its index
//   ridx_o          head index
//   full_o/empty_o  status from registered pointers
//   overflow_o/underflow_o sticky error flags
//   count_o         occupancy, only with SYNC_FIFO_COUNT_EN
module fifo_ptr_ctl
    import memory_pkg::*;
#(
    parameter  int unsigned DEPTH  = MEM_FIFO_DEPTH,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    output logic              push_o,
    output logic [ADDR_W-1:0] widx_o,
    output logic [ADDR_W-1:0] ridx_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              underflow_o
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [ADDR_W:0]   count_o
`endif
);
    typedef logic [ADDR_W:0] ptr_t;

    ptr_t wptr_q, wptr_d, rptr_q, rptr_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic push, pop;

    // Extra MSB distinguishes full from empty when the indices coincide.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                     (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

    assign push = wr_en_i & ~full_o;
    assign pop  = rd_en_i & ~empty_o;

    // Keep storage untouched in a reset cycle.
    assign push_o = push & ~rst;
    assign widx_o = wptr_q[ADDR_W-1:0];
    assign ridx_o = rptr_q[ADDR_W-1:0];

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    always_comb begin
        wptr_d      = wptr_q + ptr_t'(push);
        rptr_d      = rptr_q + ptr_t'(pop);
        overflow_d  = overflow_q  | (wr_en_i & full_o);
        underflow_d = underflow_q | (rd_en_i & empty_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_COUNT_EN
    ptr_t count_q, count_d;

    assign count_d = wptr_d - rptr_d;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word drives a downstream register stage.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  sync_fifo_if.slave: wr_en/wr_data push, rd_en pop, rd_data head (0 when empty),
//        full, empty, sticky overflow/underflow.
//   Optional macro SYNC_FIFO_COUNT_EN adds bus.count and bus.almost_full.
// DEPTH must be a power of two and at least 2.
module sync_fifo
    import memory_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = MEM_BUS_WIDTH,
    parameter int unsigned DEPTH     = MEM_FIFO_DEPTH
) (
    input logic         clk,
    input logic         rst,
    sync_fifo_if.slave  bus
);
    localparam int unsigned ADDR_W = addr_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and >= 2");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: BUS_WIDTH must be >= 1");
    end

    logic [BUS_WIDTH-1:0] mem_q [DEPTH];
    logic                 push;
    logic [ADDR_W-1:0]    widx, ridx;
    logic                 empty;

    fifo_ptr_ctl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctl (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (bus.wr_en),
        .rd_en_i     (bus.rd_en),
        .push_o      (push),
        .widx_o      (widx),
        .ridx_o      (ridx),
        .full_o      (bus.full),
        .empty_o     (empty),
        .overflow_o  (bus.overflow),
        .underflow_o (bus.underflow)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .count_o     (bus.count)
`endif
    );

    // Storage is deliberately not reset; reset only moves the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[widx] <= bus.wr_data;
        end
    end

    assign bus.empty   = empty;
    // Masked so a stale word never leaks out while empty.
    assign bus.rd_data = empty ? '0 : mem_q[ridx];

`ifdef SYNC_FIFO_COUNT_EN
    assign bus.almost_full = (bus.count >= (ADDR_W + 1)'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;
    localparam int unsigned BW = 8;
    localparam int unsigned DP = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_if #(.BUS_WIDTH(BW), .DEPTH(DP)) bus ();

    sync_fifo #(
        .BUS_WIDTH (BW),
        .DEPTH     (DP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue plus the two sticky flags.
    logic [BW-1:0] mq [$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit w, input logic [BW-1:0] d, input bit rd);
        bit was_full, was_empty;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (mq.size() == DP);
            was_empty = (mq.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
            if (rd && !was_empty) void'(mq.pop_front());
            if (w && !was_full) mq.push_back(d);
        end
    endtask

    task automatic check_state(input string tag);
        logic [BW-1:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        check_eq({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        check_eq({tag, ".full"}, 32'(bus.full), 32'(mq.size() == DP));
        check_eq({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp_data));
        check_eq({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check_eq({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
`ifdef SYNC_FIFO_COUNT_EN
        check_eq({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        check_eq({tag, ".almost_full"}, 32'(bus.almost_full), 32'(mq.size() >= DP - 1));
`endif
    endtask

    // Inputs change at negedge; outputs are checked at the following negedge.
    task automatic step(input string tag, input bit r, input bit w, input logic [BW-1:0] d,
                        input bit rd);
        rst         = r;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = rd;
        @(posedge clk);
        model_edge(r, w, d, rd);
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        int pw, pr;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        @(negedge clk);

        // Reset then idle.
        step("rst", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0);

        // FWFT ordering.
        step("push1", 0, 1, 8'd1, 0);
        step("push30", 0, 1, 8'd30, 0);
        step("push31", 0, 1, 8'd31, 0);
        for (int i = 0; i < 3; i++) step("pop3", 0, 0, 0, 1);

        // Overfill: 9th push dropped, drain yields 1..8.
        step("rst2", 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step("fill9", 0, 1, 8'(i), 0);
        for (int i = 0; i < 9; i++) step("drain", 0, 0, 0, 1);

        // Push+pop while full: pop taken, 33 rejected.
        step("rst3", 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step("fill8", 0, 1, 8'(i + 100), 0);
        step("fullpp", 0, 1, 8'd33, 1);
        for (int i = 0; i < 8; i++) step("drain2", 0, 0, 0, 1);

        // Half-full streaming across pointer wrap.
        step("rst4", 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step("half", 0, 1, 8'(i), 0);
        for (int i = 0; i < 20; i++) step("stream", 0, 1, 8'($urandom), 1);

        // Empty pop, then push+pop into empty (no bypass).
        step("rst5", 1, 0, 0, 0);
        step("epop", 0, 0, 0, 1);
        step("rst6", 1, 0, 0, 0);
        step("emptypp", 0, 1, 8'd77, 1);
        step("pop77", 0, 0, 0, 1);

        // Reset mid-burst with requests asserted; then push 32.
        step("rst7", 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step("burst", 0, 1, 8'(i + 50), 0);
        step("midrst", 1, 1, 8'd99, 1);
        step("push32", 0, 1, 8'd32, 0);
        step("pop32", 0, 0, 0, 1);

        // Randomised phases with occasional resets.
        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 150; i++) begin
                step("rand", ($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < pw),
                     8'($urandom), ($urandom_range(0, 99) < pr));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
